// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: per-register pending-write scoreboard, RAW stall, branch flush, stall watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int CNT_W       = 2,
    parameter int STALL_LIMIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_reg_write,
    input  logic [4:0]          id_rd,
    input  logic                ex_branch_taken,
    input  logic                wb_reg_write,
    input  logic [4:0]          wb_rd,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_id_flush,
    output logic                id_ex_bubble,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [1:0]          state,
    output logic [2:0]          err,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         flush_cycles
);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam int SR_W = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SR_W-1:0]  SR_LAST = SR_W'(STALL_LIMIT - 1);

    logic [1:0]          state_reg, state_next;
    logic [SR_W-1:0]     stall_run_reg, stall_run_next;
    logic [2:0]          err_reg, err_next;
    logic [NUM_REGS-1:0] ovf_vec, unf_vec;
    logic                halted, hazard, wd_trip;
    logic                stall_cycle, flush_cycle;

    assign halted = (state_reg == ST_HALT);

    // A register retiring in WB this cycle still reads as busy: the register file is not write-through.
    assign hazard = id_valid & ((id_use_rs & busy_mask[id_rs]) | (id_use_rt & busy_mask[id_rt]));

    // Cycle classes after priority resolution; reset is handled separately.
    assign flush_cycle = ~halted & ex_branch_taken;
    assign stall_cycle = ~halted & ~ex_branch_taken & hazard;
    assign wd_trip     = stall_cycle & (stall_run_reg == SR_LAST);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        issue        = id_valid;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            issue        = 1'b0;
        end else if (halted) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            issue        = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            issue        = 1'b0;
        end else if (hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            issue        = 1'b0;
        end
    end

    // Per-register pending-write counters; register 0 is hardwired idle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign busy_mask[gi] = 1'b0;
                assign ovf_vec[gi]   = 1'b0;
                assign unf_vec[gi]   = 1'b0;
            end else begin : g_track
                logic [CNT_W-1:0] cnt_reg;
                logic             inc, dec;

                assign inc = issue & id_reg_write & (id_rd == 5'(gi));
                assign dec = wb_reg_write & (wb_rd == 5'(gi));

                assign busy_mask[gi] = (cnt_reg != '0);
                assign ovf_vec[gi]   = inc & ~dec & (cnt_reg == CNT_MAX);
                assign unf_vec[gi]   = dec & ~inc & (cnt_reg == '0);

                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_reg <= '0;
                    end else if (inc && !dec && cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (dec && !inc && cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        state_next     = ST_RUN;
        stall_run_next = '0;
        if (halted) begin
            state_next     = ST_HALT;
            stall_run_next = stall_run_reg;
        end else if (ex_branch_taken) begin
            state_next = ST_FLUSH;
        end else if (hazard) begin
            state_next     = wd_trip ? ST_HALT : ST_STALL;
            stall_run_next = stall_run_reg + 1'b1;
        end
    end

    assign err_next = err_reg | {wd_trip, |ovf_vec, |unf_vec};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            stall_run_reg <= '0;
            err_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            stall_run_reg <= stall_run_next;
            err_reg       <= err_next;
        end
    end

    assign state = state_reg;
    assign err   = err_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_reg, flush_cnt_reg;

    // Both counters freeze in HALT because the cycle classes exclude it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_cycle) stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (flush_cycle) flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_cycles = flush_cnt_reg;
`else
    assign stall_cycles = 32'd0;
    assign flush_cycles = 32'd0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard controller for the 5-stage IF/ID/EX/DM/WB core. It keeps a per-register scoreboard of in-flight writes, stalls the ID stage on read-after-write hazards, and flushes the front end when EX resolves a taken branch. It also runs a stall watchdog that halts the pipeline on deadlock. It sits beside the ID stage and drives the PC, IF_ID and ID_EX register controls.

## Interface
- NUM_REGS, 32: architectural registers; register 0 is never tracked.
- CNT_W, 2: width of the pending-write counter per register. The maximum value, 3, covers the EX, DM and WB stages in flight.
- STALL_LIMIT, 16: number of consecutive stall cycles that trips the watchdog.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  5  source register numbers of the ID instruction.
- id_use_rs, id_use_rt  in  1  the ID instruction reads rs / rt.
- id_reg_write  in  1  the ID instruction writes a register.
- id_rd  in  5  destination register, after the reg_dst mux.
- ex_branch_taken  in  1  the branch in EX resolved taken this cycle.
- wb_reg_write, wb_rd  in  1, 5  register write committing in WB this cycle.
- pc_write  out  1  when 0, the PC holds.
- if_id_write  out  1  when 0, IF_ID holds.
- if_id_flush  out  1  clears IF_ID to a NOP.
- id_ex_bubble  out  1  loads zeroed control into ID_EX.
- issue  out  1  the ID instruction advances to EX this cycle.
- busy_mask  out  NUM_REGS  bit r is set while pending[r] != 0.
- state  out  2  RUN=0, STALL=1, FLUSH=2, HALT=3.
- err  out  3  sticky error flags: [0] underflow, [1] overflow, [2] watchdog.
- stall_cycles, flush_cycles  out  32  performance counters (see Configuration).

## Operation
- hazard = id_valid & ((id_use_rs & busy[id_rs]) | (id_use_rt & busy[id_rt])).
  - Register 0 is never busy.
  - A write committing in WB this same cycle still counts as busy. The register file is not write-through.
- Priority order: reset > HALT > ex_branch_taken > hazard > normal.
- Reset cycle outputs:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, issue=0.
- HALT outputs:
  - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, issue=0.
- Branch-taken outputs:
  - pc_write=1 (the PC loads the target), if_id_write=1, if_id_flush=1, id_ex_bubble=1, issue=0.
  - The instruction in ID is squashed and never scoreboarded.
- Hazard outputs:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, issue=0, if_id_flush=0.
- Normal outputs:
  - pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, issue=id_valid.
- Scoreboard update, per register r != 0, at each edge:
  - inc = issue & id_reg_write & (id_rd==r).
  - dec = wb_reg_write & (wb_rd==r).
  - inc & dec: the count is unchanged.
  - inc alone at the maximum count: the count holds and err[1] is set.
  - dec alone at zero: the count holds and err[0] is set.
  - Writes to register 0 are ignored without error.
- FSM: the registered state records the class of the cycle just completed.
  - The next state is FLUSH on a taken branch, STALL on a hazard, otherwise RUN.
  - HALT is absorbing and is exited only by reset.
- Watchdog: stall_run counts consecutive hazard cycles.
  - It clears on any non-hazard cycle.
  - When stall_run reaches STALL_LIMIT, the FSM enters HALT and err[2] is set.
  - The scoreboard keeps decrementing on WB while in HALT.

## Timing
- All control outputs are combinational from the current inputs plus the registered scoreboard and state. They are valid before the same edge at which the pipeline registers load.
- Scoreboard latency: an issue at edge N makes busy visible from cycle N+1. A WB commit at edge N clears busy from cycle N+1.
- A dependent instruction immediately after its producer stalls 3 cycles. It issues in the cycle after the producer's WB edge.
- A taken branch causes exactly 1 flush cycle with no extra bubbles.
- After reset deasserts: pending=0, busy_mask=0, state=RUN, err=0, stall_run=0, counters=0.
- Reset asserted mid-stall or in HALT: everything returns to those values at the next edge.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on each hazard cycle.
  - flush_cycles increments on each branch-flush cycle.
  - Both are 32-bit, wrap modulo 2^32, clear on reset, and are frozen in HALT.
- HAZARD_PERF_CNT_EN undefined: the ports remain present and are tied to 0. No counter flops are generated.

## Test plan
- Producer writes r5 and the next instruction reads r5: hazard for 3 cycles, pc_write=0, id_ex_bubble=1, state=STALL; the dependent instruction issues on cycle 4; busy_mask[5] clears after the WB edge.
- ex_branch_taken=1 while the ID instruction also has a hazard: if_id_flush=1, pc_write=1, issue=0, state=FLUSH next cycle; no scoreboard increment for the squashed instruction.
- Issue a write to r7 in the same cycle as wb_rd=7 commits: pending[7] is unchanged at 1; busy_mask[7] stays 1.
- Write to r0 followed by a read of r0: never busy, no stall, err=0.
- Hold hazard with wb_reg_write=0 for 16 cycles: state=HALT, err[2]=1, pc_write=0 persists; reset returns state=RUN and err=0.
- wb_rd=9 commits with pending[9]=0: err[0]=1 and the count stays 0; with HAZARD_PERF_CNT_EN, stall_cycles matches the stall count of the earlier scenarios.
